// File: rtl/tcp_stream_tracker.sv
// tcp_stream_tracker: per-packet TCP stream lookup/insert/update/delete against an external hash stage.
// Command codes: find=0 insert=1 update=2 delete=3. Return codes: found=0 miss=1 inserted=2 success=3 deleted=4.
module tcp_stream_tracker #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [104:0]                 ch_pkt_hdr_in,
  output logic                         ch_pkt_hdr_in_ready,
  output logic [130+ADDR_W:0]          ch_hash_cmd_out,
  input  logic                         ch_hash_cmd_out_ready,
  input  logic [35+ADDR_W:0]           ch_hash_ret_in,
  output logic                         ch_hash_ret_in_ready,
  output logic [11+ADDR_W+CNT_W:0]     ch_verdict_out,
  input  logic                         ch_verdict_out_ready
);
  localparam logic [2:0] IDLE = 3'd0, FIND_REQ = 3'd1, FIND_RSP = 3'd2, OP_REQ = 3'd3, OP_RSP = 3'd4, VERDICT = 3'd5;
  localparam logic [1:0] C_FIND = 2'd0, C_INS = 2'd1, C_UPD = 2'd2, C_DEL = 2'd3;
  localparam logic [2:0] R_FOUND = 3'd0, R_INS = 3'd2, R_OK = 3'd3, R_DEL = 3'd4;
  localparam logic [2:0] V_UNTR = 3'd0, V_NEW = 3'd1, V_EXIST = 3'd2, V_CLOSED = 3'd3, V_FULL = 3'd4, V_ERR = 3'd5;
  logic [2:0]        state_q, state_d;
  logic [3:0]        flags_q, flags_d;
  logic [95:0]       key_q, key_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d, vaddr_q, vaddr_d;
  logic [2:0]        verd_q, verd_d;
  logic [CNT_W-1:0]  vcnt_q, vcnt_d;
  logic [7:0]        vst_q, vst_d;
  logic [ADDR_W:0]   live_q, live_d;
  logic [31:0]       src_ip, dst_ip;
  logic [15:0]       src_port, dst_port;
  logic              swap, hdr_fire, ret_fire, full;
  logic [95:0]       key_in;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [2:0]        r_code, exp_code;
  logic [CNT_W-1:0]  f_cnt, inc_cnt;
  logic [7:0]        f_st, up_st;
  logic              unused;
  assign src_ip   = ch_pkt_hdr_in[103:72];
  assign dst_ip   = ch_pkt_hdr_in[71:40];
  assign src_port = ch_pkt_hdr_in[39:24];
  assign dst_port = ch_pkt_hdr_in[23:8];
  assign unused   = ^{ch_pkt_hdr_in[7:5], ch_pkt_hdr_in[3]};
  assign r_addr   = ch_hash_ret_in[34+ADDR_W:35];
  assign r_data   = ch_hash_ret_in[34:3];
  assign r_code   = ch_hash_ret_in[2:0];
  // Lower endpoint always goes first so both directions hash to the same key.
  assign swap     = !(src_ip < dst_ip || (src_ip == dst_ip && src_port <= dst_port));
  assign key_in   = swap ? {dst_ip, src_ip, dst_port, src_port} : {src_ip, dst_ip, src_port, dst_port};
  assign ch_pkt_hdr_in_ready  = reset && state_q == IDLE;
  assign ch_hash_ret_in_ready = reset && (state_q == IDLE || state_q == FIND_REQ || state_q == FIND_RSP || state_q == OP_RSP);
  assign ch_hash_cmd_out = {state_q == FIND_REQ || state_q == OP_REQ, cmd_q, key_q, data_q, addr_q};
  assign ch_verdict_out  = {state_q == VERDICT, verd_q, vaddr_q, vcnt_q, vst_q};
  assign hdr_fire = ch_pkt_hdr_in[104] && ch_pkt_hdr_in_ready;
  assign ret_fire = ch_hash_ret_in[35+ADDR_W] && ch_hash_ret_in_ready;
  assign full     = live_q[ADDR_W];
  assign f_cnt    = r_data[CNT_W-1:0];
  assign f_st     = r_data[31:24];
  assign inc_cnt  = &f_cnt ? f_cnt : f_cnt + 1'b1;
  assign up_st    = (f_st == 8'd1 && flags_q[3]) ? 8'd2 : f_st;
  assign exp_code = cmd_q == C_INS ? R_INS : cmd_q == C_UPD ? R_OK : R_DEL;
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    key_d   = key_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    addr_d  = addr_q;
    verd_d  = verd_q;
    vaddr_d = vaddr_q;
    vcnt_d  = vcnt_q;
    vst_d   = vst_q;
    live_d  = live_q;
    case (state_q)
      IDLE: if (hdr_fire) begin
        state_d = FIND_REQ;
        flags_d = {ch_pkt_hdr_in[4], ch_pkt_hdr_in[2:0]};
        key_d   = key_in;
        cmd_d   = C_FIND;
        data_d  = '0;
        addr_d  = '0;
        verd_d  = V_UNTR;
        vaddr_d = '0;
        vcnt_d  = '0;
        vst_d   = '0;
      end
      FIND_REQ: state_d = ch_hash_cmd_out_ready ? FIND_RSP : FIND_REQ;
      FIND_RSP: if (ret_fire) begin
        if (r_code == R_FOUND) begin
          state_d = OP_REQ;
          addr_d  = r_addr;
          vaddr_d = r_addr;
          vcnt_d  = inc_cnt;
          cmd_d   = (flags_q[0] || flags_q[2]) ? C_DEL : C_UPD;
          verd_d  = (flags_q[0] || flags_q[2]) ? V_CLOSED : V_EXIST;
          vst_d   = (flags_q[0] || flags_q[2]) ? f_st : up_st;
          data_d  = {((flags_q[0] || flags_q[2]) ? f_st : up_st), 24'd0} | 32'(inc_cnt);
        end else if (flags_q[1] && !flags_q[2] && !full) begin
          state_d = OP_REQ;
          cmd_d   = C_INS;
          addr_d  = r_addr;
          data_d  = 32'h0100_0001;
          verd_d  = V_NEW;
          vaddr_d = r_addr;
          vcnt_d  = CNT_W'(1);
          vst_d   = 8'd1;
        end else begin
          state_d = VERDICT;
          verd_d  = (flags_q[1] && !flags_q[2]) ? V_FULL : V_UNTR;
        end
      end
      OP_REQ: state_d = ch_hash_cmd_out_ready ? OP_RSP : OP_REQ;
      OP_RSP: if (ret_fire) begin
        state_d = VERDICT;
        if (r_code != exp_code) verd_d = V_ERR;
        else if (cmd_q == C_INS) begin
          vaddr_d = r_addr;
          live_d  = full ? live_q : live_q + 1'b1;
        end else if (cmd_q == C_DEL) live_d = live_q == '0 ? live_q : live_q - 1'b1;
      end
      VERDICT: state_d = ch_verdict_out_ready ? IDLE : VERDICT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      flags_q <= '0;
      key_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      verd_q  <= '0;
      vaddr_q <= '0;
      vcnt_q  <= '0;
      vst_q   <= '0;
      live_q  <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      key_q   <= key_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      verd_q  <= verd_d;
      vaddr_q <= vaddr_d;
      vcnt_q  <= vcnt_d;
      vst_q   <= vst_d;
      live_q  <= live_d;
    end
  end
endmodule
